// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register: captures execute-stage results and controls, owns the
// architectural NZVC flags, resolves conditional branches and counts issued instructions.
module ex_mem_stage_reg #(
    parameter int DATA_W = 24,
    parameter int RD_W   = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     ex_valid,
    input  logic signed [DATA_W-1:0] ex_result,
    input  logic                     ex_z,
    input  logic                     ex_n,
    input  logic                     ex_v,
    input  logic                     ex_c,
    input  logic                     ex_set_flags,
    input  logic        [DATA_W-1:0] ex_store_data,
    input  logic        [RD_W-1:0]   ex_rd,
    input  logic                     ex_reg_write,
    input  logic                     ex_mem_read,
    input  logic                     ex_mem_write,
    input  logic                     ex_is_branch,
    input  logic        [3:0]        ex_cond,
    output logic                     mem_valid,
    output logic signed [DATA_W-1:0] mem_result,
    output logic        [DATA_W-1:0] mem_store_data,
    output logic        [RD_W-1:0]   mem_rd,
    output logic                     mem_reg_write,
    output logic                     mem_mem_read,
    output logic                     mem_mem_write,
    output logic                     mem_branch_taken,
    output logic        [3:0]        flags_nzvc,
    output logic        [CNT_W-1:0]  mem_count
);

    logic                     valid_q, valid_d;
    logic signed [DATA_W-1:0] result_q, result_d;
    logic        [DATA_W-1:0] store_q, store_d;
    logic        [RD_W-1:0]   rd_q, rd_d;
    logic                     rw_q, rw_d;
    logic                     mr_q, mr_d;
    logic                     mw_q, mw_d;
    logic                     bt_q, bt_d;
    logic        [3:0]        flags_q, flags_d;
    logic        [CNT_W-1:0]  count_q, count_d;

    // Flags arrive packed as {N,Z,V,C}.
    function automatic logic cond_met(input logic [3:0] cond, input logic [3:0] nzvc);
        logic n, z, v, c;
        n = nzvc[3];
        z = nzvc[2];
        v = nzvc[1];
        c = nzvc[0];
        case (cond)
            4'b0000: cond_met = 1'b1;
            4'b0001: cond_met = z;
            4'b0010: cond_met = !z;
            4'b0011: cond_met = (n != v);
            4'b0100: cond_met = (n == v);
            4'b0101: cond_met = !z && (n == v);
            4'b0110: cond_met = z || (n != v);
            4'b0111: cond_met = c;
            4'b1000: cond_met = !c;
            default: cond_met = 1'b0;
        endcase
    endfunction

    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        store_d  = store_q;
        rd_d     = rd_q;
        rw_d     = rw_q;
        mr_d     = mr_q;
        mw_d     = mw_q;
        bt_d     = bt_q;
        flags_d  = flags_q;
        count_d  = count_q;
        if (flush) begin
            // Bubble: zero the slot but leave flags and count untouched.
            valid_d  = 1'b0;
            result_d = '0;
            store_d  = '0;
            rd_d     = '0;
            rw_d     = 1'b0;
            mr_d     = 1'b0;
            mw_d     = 1'b0;
            bt_d     = 1'b0;
        end else if (!stall) begin
            valid_d  = ex_valid;
            result_d = ex_result;
            store_d  = ex_store_data;
            rd_d     = ex_rd;
            rw_d     = ex_valid & ex_reg_write;
            mr_d     = ex_valid & ex_mem_read;
            mw_d     = ex_valid & ex_mem_write;
            // Uses the flags held before this edge, never the ones being written now.
            bt_d     = ex_valid & ex_is_branch & cond_met(ex_cond, flags_q);
            if (ex_valid && ex_set_flags) begin
                flags_d = {ex_n, ex_z, ex_v, ex_c};
            end
            if (ex_valid) begin
                count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            store_q  <= '0;
            rd_q     <= '0;
            rw_q     <= 1'b0;
            mr_q     <= 1'b0;
            mw_q     <= 1'b0;
            bt_q     <= 1'b0;
            flags_q  <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            store_q  <= store_d;
            rd_q     <= rd_d;
            rw_q     <= rw_d;
            mr_q     <= mr_d;
            mw_q     <= mw_d;
            bt_q     <= bt_d;
            flags_q  <= flags_d;
            count_q  <= count_d;
        end
    end

    assign mem_valid        = valid_q;
    assign mem_result       = result_q;
    assign mem_store_data   = store_q;
    assign mem_rd           = rd_q;
    assign mem_reg_write    = rw_q;
    assign mem_mem_read     = mr_q;
    assign mem_mem_write    = mw_q;
    assign mem_branch_taken = bt_q;
    assign flags_nzvc       = flags_q;
    assign mem_count        = count_q;

endmodule
